// File: rtl/str_fifo.sv
// str_fifo: valid/ready stream FIFO with DEPTH-entry circular store and fill-level flags.
module str_fifo #(
    parameter int VW       = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [VW-1:0] s_tvalue,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [VW-1:0] m_tvalue,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "str_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "str_fifo: AF_LEVEL must be in 1..DEPTH");
    end

    localparam logic [AW:0] ONE  = (AW + 1)'(1);
    localparam logic [AW:0] AF   = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};

    logic [VW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          push, pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign count       = wr_ptr - rd_ptr;
    assign full        = (wr_ptr ^ rd_ptr) == WRAP;
    assign empty       = wr_ptr == rd_ptr;
    assign almost_full = count >= AF;
    assign s_tready    = ~full & ~rst;
    assign m_tvalid    = ~empty;
    assign m_tvalue    = mem[rd_ptr[AW-1:0]];
    assign push        = s_tvalid & s_tready;
    assign pop         = m_tvalid & m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + ONE : wr_ptr;
            rd_ptr <= pop ? rd_ptr + ONE : rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tvalue;
    end
endmodule

// File: tb/tb_str_fifo.sv
// tb_str_fifo: directed vector table plus hand-written corner sequences for str_fifo.
module tb_str_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tvalue = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tvalue;
    logic [3:0]  count;
    logic        full, empty, almost_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        int          cnt;
        logic [31:0] hd;
    } vec_t;

    vec_t tv [17];

    str_fifo #(.VW(32), .DEPTH(8), .AF_LEVEL(6)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tvalue(s_tvalue),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tvalue(m_tvalue),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, int cnt, logic [31:0] hd);
        chk({tag, " count"}, {28'b0, count}, cnt);
        chk({tag, " full"}, full, cnt == 8);
        chk({tag, " empty"}, empty, cnt == 0);
        chk({tag, " almost_full"}, almost_full, cnt >= 6);
        chk({tag, " s_tready"}, s_tready, cnt != 8);
        chk({tag, " m_tvalid"}, m_tvalid, cnt != 0);
        if (cnt != 0) chk({tag, " m_tvalue"}, m_tvalue, hd);
    endtask

    task automatic step(logic sv, logic [31:0] sd, logic mr);
        s_tvalid = sv;
        s_tvalue = sd;
        m_tready = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tv[i] = '{1'b1, 32'(i), 1'b0, i + 1, 32'h0};
        tv[8] = '{1'b1, 32'h99, 1'b0, 8, 32'h0};
        for (int k = 0; k < 8; k++) tv[9 + k] = '{1'b0, 32'h0, 1'b1, 7 - k, 32'(k + 1)};

        #1;
        chk("reset count", {28'b0, count}, 0);
        chk("reset empty", empty, 1'b1);
        chk("reset full", full, 1'b0);
        chk("reset almost_full", almost_full, 1'b0);
        chk("reset m_tvalid", m_tvalid, 1'b0);
        chk("reset s_tready", s_tready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("release s_tready", s_tready, 1'b1);

        for (int i = 0; i < 17; i++) begin
            step(tv[i].sv, tv[i].sd, tv[i].mr);
            check_state($sformatf("vec%0d", i), tv[i].cnt, tv[i].hd);
        end

        step(1'b1, 32'hDEADBEEF, 1'b1);
        check_state("latency push", 1, 32'hDEADBEEF);
        step(1'b0, 32'h0, 1'b1);
        check_state("latency pop", 0, 32'h0);

        for (int i = 0; i < 100; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b1);
            chk($sformatf("stream%0d count", i), {28'b0, count}, 1);
            chk($sformatf("stream%0d value", i), m_tvalue, 32'h1000 + 32'(i));
        end
        step(1'b0, 32'h0, 1'b1);
        check_state("stream drain", 0, 32'h0);

        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        check_state("full fill", 8, 32'h100);
        step(1'b1, 32'h200, 1'b1);
        check_state("full pop only", 7, 32'h101);
        step(1'b1, 32'h200, 1'b1);
        check_state("full push+pop", 7, 32'h102);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check_state($sformatf("full drain%0d", k), 6 - k, k < 5 ? 32'h103 + 32'(k) : 32'h200);
        end

        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
        check_state("pre-reset", 5, 32'h300);
        s_tvalid = 1'b0;
        rst = 1'b1;
        #2;
        chk("async m_tvalid", m_tvalid, 1'b0);
        chk("async s_tready", s_tready, 1'b0);
        chk("async count", {28'b0, count}, 0);
        chk("async empty", empty, 1'b1);
        #2;
        rst = 1'b0;
        step(1'b1, 32'h55, 1'b0);
        check_state("post-reset push", 1, 32'h55);
        step(1'b0, 32'h0, 1'b1);
        check_state("post-reset pop", 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/str_fifo.md
Name: str_fifo

Overview:
- Synthesizable, parametrised stream buffer: valid/ready input port (s_), valid/ready output port (m_), DEPTH-entry circular store.
- Decouples a stream source from its drain. Absorbs back-pressure and bursts between producer and consumer blocks.
- Adds fill-level visibility: count, full, empty and a programmable almost-full flag.
- Uses the same tvalid/tready/tvalue transfer semantics as the existing stream source/drain bench components, so those components drive and sink it directly.

Parameters:
- VW, 32, value width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
- AW, $clog2(DEPTH), derived pointer index width; not to be overridden

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- s_tvalid  input  1  source presents a value
- s_tready  output  1  FIFO can accept a value
- s_tvalue  input  VW  input value
- m_tvalid  output  1  FIFO presents a value
- m_tready  input  1  drain accepts the value
- m_tvalue  output  VW  output value (head of FIFO)
- count  output  AW+1  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL

Behaviour:
- Transfer rules:
  - Push occurs on a rising clk edge with s_tvalid & s_tready.
  - Pop occurs on a rising clk edge with m_tvalid & m_tready.
  - The source must hold s_tvalue stable while s_tvalid is high and s_tready is low. The FIFO does not check this.
- Reset (rst high, asynchronous): write/read pointers = 0, count = 0, empty = 1, full = 0, almost_full = 0, m_tvalid = 0, s_tready = 0.
  - Storage RAM is not reset.
  - m_tvalue is don't-care while m_tvalid = 0.
- After rst deasserts: s_tready = 1 combinationally. The first rising edge with rst low can accept a push.
- s_tready = ~full & ~rst.
- m_tvalid = ~empty.
- m_tvalue = mem[rd_ptr[AW-1:0]]. Combinational read of the registered pointer; no output register.
- Latency: a value pushed at edge N appears on m_tvalue with m_tvalid = 1 after edge N (first-word latency 1 clock). It can be popped at edge N+1 at the earliest.
- Pointers are AW+1 bits wide and wrap naturally modulo 2*DEPTH.
  - Index = low AW bits.
  - full  <=> (wr_ptr ^ rd_ptr) == {1'b1, AW zeros}.
  - empty <=> wr_ptr == rd_ptr.
- count = wr_ptr - rd_ptr (AW+1 bits, modulo arithmetic).
  - count, full, empty and almost_full are combinational from the pointers; all are consistent within the same cycle.
- Simultaneous push and pop (0 < count < DEPTH): both pointers advance; count unchanged; flags unchanged.
- Full: s_tready = 0, so no push even if a pop occurs in the same cycle. After the pop, s_tready rises in the next cycle. No write-through when full.
- Empty: m_tvalid = 0, so no pop. A same-cycle push is stored and is not bypassed to the output.
- Once m_tvalid = 1, m_tvalue is stable until the pop edge. Head entry is never overwritten: writes target a different index unless full, and writes are blocked when full.
- Ordering is strict FIFO. No value is duplicated or dropped.
- Reset mid-operation: all contents discarded immediately (asynchronous). m_tvalid and s_tready drop in the same cycle rst rises, with no wait for a clock edge.
- Elaboration check: fatal error if DEPTH is not a power of two, DEPTH < 2, or AF_LEVEL is outside 1..DEPTH.

Test Plan:
- Fill/drain, VW=32, DEPTH=8: push 0x00..0x07 with m_tready=0 -> count 1..8, full=1 after 8th push, s_tready=0. Set m_tready=1 -> 0x00..0x07 popped in order, empty=1, count=0.
- Latency: single push 0xDEADBEEF at edge N -> m_tvalid=1 and m_tvalue=0xDEADBEEF immediately after edge N; popped at edge N+1 with m_tready=1.
- Streaming: s_tvalid and m_tready held high for 100 cycles, incrementing values -> after first-word latency, one transfer per cycle; count stays 1; output sequence equals input sequence.
- Full with simultaneous pop: count=8, s_tvalid=1, m_tready=1 -> pop only, count=7. Next edge: push and pop both occur, count stays 7.
- almost_full, AF_LEVEL=6: push 6 values -> almost_full rises after the 6th push edge. Pop one -> almost_full falls.
- Reset mid-stream: count=5, assert rst between edges -> m_tvalid=0, s_tready=0, count=0, empty=1 without a clock edge. Release, push 0x55 -> 0x55 is the first value out.
